// File: rtl/subtractor_16bits_serial.sv
// Multi-cycle subtract-with-borrow: d = a - b - bin, one SLICE-bit slice per clock, LSB first.
// Single-shot start/busy/done handshake; results hold until the next completion.
module subtractor_16bits_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned N     = WIDTH / SLICE;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SW    = SLICE + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               brw_q, brw_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;

    logic [SLICE:0]     slice_sum;
    logic [WIDTH-1:0]   res_next;

    // Operand registers shift right so the active slice is always at the bottom;
    // the result fills from the top so slice 0 lands at the LSB after N cycles.
    always_comb begin
        slice_sum = {1'b0, a_q[SLICE-1:0]} - {1'b0, b_q[SLICE-1:0]} - SW'(brw_q);
        res_next  = {slice_sum[SLICE-1:0], res_q[WIDTH-1:SLICE]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        d_d     = d_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    res_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> SLICE;
                b_d   = b_q >> SLICE;
                res_d = res_next;
                brw_d = slice_sum[SLICE];
                cnt_d = cnt_q + CNT_W'(1);
                // Last slice: commit the whole result at once.
                if (cnt_q == CNT_W'(N - 1)) begin
                    d_d     = res_next;
                    bout_d  = slice_sum[SLICE];
                    ovf_d   = (a_msb_q ^ b_msb_q) & (res_next[WIDTH-1] ^ a_msb_q);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_subtractor_16bits_serial.sv
// Self-checking bench for subtractor_16bits_serial: directed table, handshake corner cases,
// and randomized operations checked against an integer-arithmetic reference model.
module tb_subtractor_16bits_serial;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] d;
    logic        bout;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    subtractor_16bits_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vbin;
        logic [15:0] ed;
        logic        ebout;
        logic        eovf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin,
                         output logic [15:0] md, output logic mbo, output logic mov);
        int diff;
        int sdiff;
        diff  = int'(ma) - int'(mb) - int'(mbin);
        sdiff = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        md    = 16'(diff);
        mbo   = (diff < 0);
        mov   = (sdiff < -32768) || (sdiff > 32767);
    endtask

    // Issue one op, check handshake timing; returns DUT results sampled in the done cycle.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                         output logic [15:0] rd, output logic rbo, output logic rov);
        int lat;
        bit got;
        @(negedge clk);
        a = ta; b = tb; bin = tbin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (done) got = 1'b1;
        end
        chk("done_latency", 32'(lat), 32'd4);
        rd = d; rbo = bout; rov = ovf;
        chk("busy_in_done", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("hold_d", 32'(d), 32'(rd));
    endtask

    vec_t        vecs[$];
    logic [15:0] rd, md, sa, sb, ss, hold_d;
    logic        rbo, rov, mbo, mov, cout;
    int          ndone, lat;

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        vecs.push_back('{16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0});
        vecs.push_back('{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0});
        vecs.push_back('{16'h2345, 16'h1111, 1'b1, 16'h1233, 1'b0, 1'b0});
        vecs.push_back('{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1});
        vecs.push_back('{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1});
        vecs.push_back('{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1});
        vecs.push_back('{16'h1234, 16'h0004, 1'b0, 16'h1230, 1'b0, 1'b0});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            do_op(vecs[i].va, vecs[i].vb, vecs[i].vbin, rd, rbo, rov);
            chk($sformatf("vec%0d_d", i), 32'(rd), 32'(vecs[i].ed));
            chk($sformatf("vec%0d_bout", i), 32'(rbo), 32'(vecs[i].ebout));
            chk($sformatf("vec%0d_ovf", i), 32'(rov), 32'(vecs[i].eovf));
        end

        // Start re-raised while busy must be ignored
        @(negedge clk);
        a = 16'h1234; b = 16'h0004; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        ndone = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        if (done) ndone++;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("busy_ignore_dones", 32'(ndone), 32'd1);
        chk("busy_ignore_d", 32'(d), 32'h1230);

        // Reset mid-run aborts without done
        @(negedge clk);
        a = 16'h5555; b = 16'h1111; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_d", 32'(d), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        do_op(16'h5555, 16'h1111, 1'b0, rd, rbo, rov);
        chk("after_abort_d", 32'(rd), 32'h4444);

        // Start held high: back-to-back ops, one per 5 cycles, d held mid-run
        @(negedge clk);
        a = 16'h0010; b = 16'h0001; bin = 1'b0; start = 1'b1;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        chk("b2b_first_d", 32'(d), 32'h000F);
        hold_d = d;
        @(negedge clk);
        a = 16'h0100;
        lat = 0;
        @(posedge clk); #1; lat++;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_hold_d", 32'(d), 32'(hold_d));
        while (!done && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        chk("b2b_spacing", 32'(lat), 32'd5);
        chk("b2b_second_d", 32'(d), 32'h00FF);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(posedge clk);

        // Random operations against the model
        for (int i = 0; i < 60; i++) begin
            sa = 16'($urandom);
            sb = 16'($urandom);
            if (i < 4) sb = sa;
            do_op(sa, sb, 1'($urandom), rd, rbo, rov);
            model(sa, sb, bin, md, mbo, mov);
            chk("rand_d", 32'(rd), 32'(md));
            chk("rand_bout", 32'(rbo), 32'(mbo));
            chk("rand_ovf", 32'(rov), 32'(mov));
        end

        // Round trip: (a + b) - b == a, borrow-out equals adder carry-out
        for (int i = 0; i < 200; i++) begin
            sa = 16'($urandom);
            sb = 16'($urandom);
            {cout, ss} = 17'(sa) + 17'(sb);
            do_op(ss, sb, 1'b0, rd, rbo, rov);
            chk("trip_d", 32'(rd), 32'(sa));
            chk("trip_bout", 32'(rbo), 32'(cout));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
